// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the registered Hack ALU.
//   state_t : FSM state encoding (IDLE, MUL, HOLD)
//   MODE_*  : command mode encodings
//   ctrl_t  : Hack control-bit bundle {zx, nx, zy, ny, f, no}
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic MODE_HACK = 1'b0;
    localparam logic MODE_MUL  = 1'b1;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } ctrl_t;

endpackage

// File: rtl/alu_if.sv
// alu_if: command and result handshake bundle for alu_seq.
//   command : in_valid, in_ready, x, y, zx/nx/zy/ny/f/no, mode
//   result  : out_valid, out_ready, out, zr, ng (+ ovf when ALU_OVF_FLAG_EN)
//   master  : the side issuing commands and consuming results
//   slave   : the ALU
// Optional macro ALU_OVF_FLAG_EN adds the ovf result flag.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx, nx, zy, ny, f, no;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
`ifdef ALU_OVF_FLAG_EN
    logic             ovf;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
        input  in_ready, out_valid, out, zr, ng, ovf
    );
    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
        output in_ready, out_valid, out, zr, ng, ovf
    );
`else
    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );
    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, mode, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
`endif
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit Hack function.
//   x, y   : raw operands
//   ctrl   : Hack control bits
//   xp, yp : pre-processed operands (also feed the multiplier)
//   res    : Hack result
//   ovf    : signed overflow of xp+yp when f=1 (only with ALU_OVF_FLAG_EN)
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  ctrl_t            ctrl,
    output logic [WIDTH-1:0] xp,
    output logic [WIDTH-1:0] yp,
`ifdef ALU_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] res
);
    logic [WIDTH-1:0] xz, yz, sum, r;

    always_comb begin
        xz  = ctrl.zx ? '0 : x;
        xp  = ctrl.nx ? ~xz : xz;
        yz  = ctrl.zy ? '0 : y;
        yp  = ctrl.ny ? ~yz : yz;
        sum = xp + yp;
        r   = ctrl.f ? sum : (xp & yp);
        res = ctrl.no ? ~r : r;
`ifdef ALU_OVF_FLAG_EN
        // Independent of no: the flag describes the add, not the inverted result.
        ovf = ctrl.f && (xp[WIDTH-1] == yp[WIDTH-1]) && (sum[WIDTH-1] != xp[WIDTH-1]);
`endif
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered Hack ALU with shift-add multiply and valid/ready handshakes.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : alu_if slave (command in, result out)
// Hack ops complete in 1 cycle; multiply takes WIDTH step cycles.
// Optional macro ALU_OVF_FLAG_EN adds the ovf flag and the upper-product logic.
//
//   state | meaning
//   IDLE  | no result pending, ready for a command
//   MUL   | shift-add multiply running, cnt 0..WIDTH-1
//   HOLD  | result valid, waiting for out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
`ifdef ALU_OVF_FLAG_EN
    localparam int PW = 2 * WIDTH;   // full product needed to see upper-half bits
`else
    localparam int PW = WIDTH;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             no_q, no_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;

    ctrl_t            ctrl_in;
    logic [WIDTH-1:0] xp, yp, hack_res, mul_res, load_val;
    logic [PW-1:0]    acc_step;
    logic             in_ready, accept, is_mul, load;
`ifdef ALU_OVF_FLAG_EN
    logic             ovf_q, ovf_d, hack_ovf, load_ovf;
`endif

    assign ctrl_in = '{zx: bus.zx, nx: bus.nx, zy: bus.zy, ny: bus.ny, f: bus.f, no: bus.no};

    alu_core #(.WIDTH(WIDTH)) u_core (
        .x    (bus.x),
        .y    (bus.y),
        .ctrl (ctrl_in),
        .xp   (xp),
        .yp   (yp),
`ifdef ALU_OVF_FLAG_EN
        .ovf  (hack_ovf),
`endif
        .res  (hack_res)
    );

    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
        accept   = bus.in_valid && in_ready;
        is_mul   = MUL_EN && (bus.mode == MODE_MUL);
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_res  = no_q ? ~acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];

        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        no_d     = no_q;
        load     = 1'b0;
        load_val = '0;
`ifdef ALU_OVF_FLAG_EN
        load_ovf = 1'b0;
`endif

        case (state_q)
            MUL: begin
                cnt_d    = cnt_q + CNT_W'(1);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_step;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = HOLD;
                    load     = 1'b1;
                    load_val = mul_res;
`ifdef ALU_OVF_FLAG_EN
                    load_ovf = |acc_step[PW-1:WIDTH];
`endif
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // accept is only possible from IDLE or a draining HOLD
        if (accept) begin
            if (is_mul) begin
                state_d  = MUL;
                cnt_d    = '0;
                mcand_d  = PW'(xp);
                mplier_d = yp;
                acc_d    = '0;
                no_d     = ctrl_in.no;
            end else begin
                state_d  = HOLD;
                load     = 1'b1;
                load_val = hack_res;
`ifdef ALU_OVF_FLAG_EN
                load_ovf = hack_ovf;
`endif
            end
        end

        // flags only move with a new result so they always describe out
        out_d = load ? load_val : out_q;
        zr_d  = load ? (load_val == '0) : zr_q;
        ng_d  = load ? load_val[WIDTH-1] : ng_q;
`ifdef ALU_OVF_FLAG_EN
        ovf_d = load ? load_ovf : ovf_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            no_q     <= 1'b0;
            out_q    <= '0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            no_q     <= no_d;
            out_q    <= out_d;
            zr_q     <= zr_d;
            ng_q     <= ng_d;
`ifdef ALU_OVF_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
`ifdef ALU_OVF_FLAG_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven bench for alu_seq at WIDTH=16.
module tb_alu_seq;
    logic clk;
    logic rst_n;

    alu_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctrl;     // {zx,nx,zy,ny,f,no}
        logic [15:0] exp_out;
        logic        exp_zr;
        logic        exp_ng;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [5:0] c, input logic mode);
        bus.in_valid = 1'b1;
        bus.x    = x;
        bus.y    = y;
        bus.zx   = c[5];
        bus.nx   = c[4];
        bus.zy   = c[3];
        bus.ny   = c[2];
        bus.f    = c[1];
        bus.no   = c[0];
        bus.mode = mode;
    endtask

    task automatic check_ovf(input string name, input logic exp);
`ifdef ALU_OVF_FLAG_EN
        check(name, {31'd0, bus.ovf}, {31'd0, exp});
`endif
    endtask

    // Called at a negedge with out_ready=1; leaves the bench at a negedge with the result showing.
    task automatic run_mul(input string name, input logic [15:0] x, input logic [15:0] y,
                           input logic [5:0] c, input logic [15:0] e_out,
                           input logic e_zr, input logic e_ng, input logic e_ovf);
        int cycles;
        logic bad_ready;
        set_op(x, y, c, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x = 16'hDEAD;   // later operand changes must be ignored
        bus.y = 16'hBEEF;
        cycles = 1;
        bad_ready = 1'b0;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            if (bus.in_ready !== 1'b0) bad_ready = 1'b1;
            @(negedge clk);
            cycles++;
        end
        check({name, " latency"}, cycles, 17);
        check({name, " in_ready low"}, {31'd0, bad_ready}, 32'd0);
        check({name, " out"}, {16'd0, bus.out}, {16'd0, e_out});
        check({name, " zr"}, {31'd0, bus.zr}, {31'd0, e_zr});
        check({name, " ng"}, {31'd0, bus.ng}, {31'd0, e_ng});
        check_ovf({name, " ovf"}, e_ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0011, 16'h0003, 6'b000010, 16'h0014, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0011, 16'h0003, 6'b111111, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0011, 16'h0003, 6'b000000, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0005, 16'h0003, 6'b010011, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h00F0, 16'h1234, 6'b001101, 16'hFF0F, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h0005, 16'h0003, 6'b000111, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h00F0, 16'h0F00, 6'b010101, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0, 1'b0};

        // Reset held with a command pending
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        set_op(16'h0011, 16'h0003, 6'b000010, 1'b0);
        repeat (3) @(negedge clk);
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst out", {16'd0, bus.out}, 32'd0);
        check("rst zr", {31'd0, bus.zr}, 32'd0);
        check("rst ng", {31'd0, bus.ng}, 32'd0);
        check_ovf("rst ovf", 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first accept out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("first accept out", {16'd0, bus.out}, 32'h0014);

        // Back-to-back Hack vectors, one per cycle
        for (int i = 0; i < 10; i++) begin
            set_op(vecs[i].x, vecs[i].y, vecs[i].ctrl, 1'b0);
            check($sformatf("vec%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("vec%0d out", i), {16'd0, bus.out}, {16'd0, vecs[i].exp_out});
            check($sformatf("vec%0d zr", i), {31'd0, bus.zr}, {31'd0, vecs[i].exp_zr});
            check($sformatf("vec%0d ng", i), {31'd0, bus.ng}, {31'd0, vecs[i].exp_ng});
            check_ovf($sformatf("vec%0d ovf", i), vecs[i].exp_ovf);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Multiply
        run_mul("mul", 16'h0011, 16'h0003, 6'b000000, 16'h0033, 1'b0, 1'b0, 1'b0);
        run_mul("mul no", 16'h0011, 16'h0003, 6'b000001, 16'hFFCC, 1'b0, 1'b1, 1'b0);
        run_mul("mul neg", 16'h0002, 16'h0003, 6'b010000, 16'hFFF7, 1'b0, 1'b1, 1'b1);
        run_mul("mul wrap", 16'h0100, 16'h0100, 6'b000000, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // Backpressure: result held, next command waits
        bus.out_ready = 1'b0;
        set_op(16'h0000, 16'hFFFF, 6'b101010, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_op(16'h0011, 16'h0003, 6'b000010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp%0d out", i), {16'd0, bus.out}, 32'h0000);
            check($sformatf("bp%0d zr", i), {31'd0, bus.zr}, 32'd1);
            check($sformatf("bp%0d in_ready", i), {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp release out", {16'd0, bus.out}, 32'h0000);
        @(posedge clk);
        @(negedge clk);
        check("bp next out", {16'd0, bus.out}, 32'h0014);
        check("bp next zr", {31'd0, bus.zr}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset on cycle 8 of a multiply
        begin
            logic seen_valid;
            set_op(16'h0011, 16'h0003, 6'b000000, 1'b1);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (7) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("mid-mul rst out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("mid-mul rst out", {16'd0, bus.out}, 32'h0000);
            @(negedge clk);
            rst_n = 1'b1;
            seen_valid = 1'b0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
            end
            check("aborted mul no result", {31'd0, seen_valid}, 32'd0);
            set_op(16'h0011, 16'h0003, 6'b000000, 1'b0);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("post-abort out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("post-abort out", {16'd0, bus.out}, 32'h0001);
            @(negedge clk);
        end

`ifdef ALU_OVF_FLAG_EN
        set_op(16'h7FFF, 16'h0001, 6'b000010, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ovf add out", {16'd0, bus.out}, 32'h8000);
        check("ovf add ng", {31'd0, bus.ng}, 32'd1);
        check("ovf add ovf", {31'd0, bus.ovf}, 32'd1);
        @(negedge clk);
        set_op(16'h7FFF, 16'h0001, 6'b000011, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ovf add no out", {16'd0, bus.out}, 32'h7FFF);
        check("ovf add no ovf", {31'd0, bus.ovf}, 32'd1);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational Hack ALU. Computes the full Hack function set (zx/nx/zy/ny/f/no) at configurable WIDTH. Adds a multi-cycle shift-add multiply mode. Input and output use valid/ready handshakes, so the block sits between operand fetch and writeback in the pipelined CPU datapath.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4)
MUL_EN, 1, 1 = multiply mode available; 0 = mode input ignored and treated as Hack mode

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/command valid
in_ready  out  1  block can accept a command this cycle
x  in  WIDTH  operand x
y  in  WIDTH  operand y
zx, nx, zy, ny, f, no  in  1 each  Hack control bits
mode  in  1  0 = Hack ALU op, 1 = multiply (pre-processed x * pre-processed y)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out  out  WIDTH  result
zr  out  1  out == 0
ng  out  1  out[WIDTH-1]

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE; out_valid=0; out=0; zr=0; ng=0; in_ready=1 one cycle after release (combinational from state).
- Transfer: input on in_valid&&in_ready at rising edge; output on out_valid&&out_ready.
- Pre-processing (both modes): xp = nx ? ~(zx?0:x) : (zx?0:x); yp likewise with zy/ny.
- Hack mode: r = f ? xp+yp (mod 2^WIDTH, carry dropped) : xp&yp; out = no ? ~r : r.
  - Registered; out_valid rises the cycle after acceptance (latency 1).
- Multiply mode: r = low WIDTH bits of xp*yp (unsigned, equals two's-complement low half). Computed by shift-add, one bit per cycle, then out = no ? ~r : r.
  - Latency WIDTH+1 cycles from acceptance to out_valid.
- zr/ng are registered with out, always consistent with the out value; they are held while out_valid=0.
- States:
  - IDLE: no result pending.
  - MUL: counter runs 0..WIDTH-1.
  - HOLD: out_valid=1, waiting for out_ready.
- Transitions:
  - IDLE --accept Hack--> HOLD
  - IDLE --accept mul--> MUL
  - MUL --count==WIDTH-1--> HOLD
  - HOLD --out_ready, no accept--> IDLE
  - HOLD --out_ready & accept Hack--> HOLD (new result)
  - HOLD --out_ready & accept mul--> MUL
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Full throughput of 1 op/cycle in Hack mode with out_ready tied high.
- Backpressure: in HOLD with out_ready=0, out/zr/ng stay stable and in_ready=0.
- in_ready=0 throughout MUL. Inputs (x, y, control bits, mode) are sampled only at acceptance; later changes are ignored.
- Reset mid-multiply aborts the operation: state=IDLE, no result emitted.
- With MUL_EN=0, mode=1 is executed as a Hack op.

Optional Feature:
ALU_OVF_FLAG_EN: adds output port ovf (1 bit).
- Registered with out.
- Hack f=1: ovf = signed overflow of xp+yp, i.e. operand signs equal and sum sign differs.
- Multiply: ovf = 1 if the full 2*WIDTH unsigned product has any nonzero upper-half bit.
- Logical op: ovf = 0. Reset value 0.
- The no bit does not affect ovf.
- Without the macro: no ovf port, and no upper-product or sign logic is synthesised.

Decomposition:
- Package alu_pkg: state encoding localparams (IDLE, MUL, HOLD); mode encodings (MODE_HACK=0, MODE_MUL=1); control-bit bundle typedef {zx,nx,zy,ny,f,no}.
- Sub-module alu_core: parametrised combinational WIDTH-bit Hack function (pre-processing, f-select, no), reused for single-cycle results and for xp/yp generation.
- alu_seq holds the FSM, the multiply datapath and the output register.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0, out=0, zr=0, ng=0 until release; first accept on the first cycle after release.
- WIDTH=16, x=0x0011, y=0x0003, f=1, other controls 0, out_ready=1 -> next cycle out=0x0014, zr=0, ng=0. Back-to-back op zx=nx=zy=ny=f=no=1 accepted the same cycle -> following cycle out=0x0001.
- Multiply x=0x0011, y=0x0003, mode=1, controls 0 -> in_ready=0 for 16 cycles, out=0x0033 on cycle 17. Same with no=1 -> out=0xFFCC, ng=1.
- Backpressure: Hack x=0, y=0xFFFF, zx=zy=1, f=1 with out_ready=0 for 5 cycles -> out=0x0000, zr=1 stable, in_ready=0; the result is transferred on the first out_ready=1.
- Reset asserted on cycle 8 of a multiply -> out_valid never rises for that op; the next accepted Hack op x=0x0011, y=0x0003, f=0 gives out=0x0001.
- With ALU_OVF_FLAG_EN: x=0x7FFF, y=0x0001, f=1 -> out=0x8000, ng=1, ovf=1. Multiply 0x0100*0x0100 -> out=0x0000, zr=1, ovf=1.
